xy_router_rr: RTL and testbench

XY_ROUTER_RR -- requirements
Module: xy_router_rr

---
 rtl/xy_router_rr.sv | 190 +++++++++++++++++++
 tb/tb_xy_router_rr.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy_router_rr.sv
// -----------------------------------------------------------------------------
// xy_router_rr
// Five-port 2-D mesh/torus router with dimension-ordered (X then Y) routing,
// per-input FIFOs and per-output fixed-priority or round-robin arbitration.
//
// Port index map (all 5-bit vectors and 5*PW packet buses):
//   0 local, 1 left, 2 up, 3 right, 4 down. Lane p = bits [PW*(p+1)-1:PW*p].
// Packet layout: [CA-1:0] dst col, [CA+RA-1:CA] dst row, upper bits payload.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   wr_en_i     per-port write strobe from upstream
//   pckt_i      per-port incoming packet
//   full_o      per-port almost-full to upstream (count >= DEPTH-1)
//   ovrflw_o    per-port sticky overflow flag
//   nxt_full_i  per-port almost-full from downstream
//   wr_en_o     per-port registered write strobe to downstream
//   pckt_o      per-port registered outgoing packet
//   drop_cnt_o  saturating count of dropped packets (overflow + bad address)
// -----------------------------------------------------------------------------
module xy_router_rr #(
   parameter int ROW_N        = 3,
   parameter int COL_M        = 3,
   parameter int ROW_CORD     = 0,
   parameter int COL_CORD     = 0,
   parameter int PCKT_DATA_W  = 8,
   parameter int FIFO_DEPTH_W = 2,
   parameter int TORUS        = 0,
   parameter int ARB_TYPE     = 1
) (
   input  logic                                                   clk_i,
   input  logic                                                   rst_i,
   input  logic [4:0]                                             wr_en_i,
   input  logic [5*(PCKT_DATA_W+$clog2(ROW_N)+$clog2(COL_M))-1:0] pckt_i,
   output logic [4:0]                                             full_o,
   output logic [4:0]                                             ovrflw_o,
   input  logic [4:0]                                             nxt_full_i,
   output logic [4:0]                                             wr_en_o,
   output logic [5*(PCKT_DATA_W+$clog2(ROW_N)+$clog2(COL_M))-1:0] pckt_o,
   output logic [7:0]                                             drop_cnt_o
);

   localparam int CA       = $clog2(COL_M);
   localparam int RA       = $clog2(ROW_N);
   localparam int PW       = PCKT_DATA_W + RA + CA;
   localparam int DEPTH    = 2 ** FIFO_DEPTH_W;
   localparam int DEPTH_M1 = DEPTH - 1;
   localparam int NP       = 5;

   localparam logic [FIFO_DEPTH_W:0] CNT_DEPTH  = DEPTH[FIFO_DEPTH_W:0];
   localparam logic [FIFO_DEPTH_W:0] CNT_ALMOST = DEPTH_M1[FIFO_DEPTH_W:0];

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_LEFT  = 3'd1;
   localparam logic [2:0] PORT_UP    = 3'd2;
   localparam logic [2:0] PORT_RIGHT = 3'd3;
   localparam logic [2:0] PORT_DOWN  = 3'd4;

   // X first, then Y. In torus mode each dimension picks the shorter wrap
   // direction; a tie (distance exactly half the ring) goes right/down.
   function automatic logic [2:0] calc_route(input int col, input int row);
      int d;
      d          = 0;
      calc_route = PORT_LOCAL;
      if (col != COL_CORD) begin
         if (TORUS != 0) begin
            d          = (col >= COL_CORD) ? col - COL_CORD : col + COL_M - COL_CORD;
            calc_route = (d <= COL_M / 2) ? PORT_RIGHT : PORT_LEFT;
         end else begin
            calc_route = (col > COL_CORD) ? PORT_RIGHT : PORT_LEFT;
         end
      end else if (row != ROW_CORD) begin
         if (TORUS != 0) begin
            d          = (row >= ROW_CORD) ? row - ROW_CORD : row + ROW_N - ROW_CORD;
            calc_route = (d <= ROW_N / 2) ? PORT_DOWN : PORT_UP;
         end else begin
            calc_route = (row > ROW_CORD) ? PORT_DOWN : PORT_UP;
         end
      end
   endfunction

   logic [PW-1:0]           mem     [NP][DEPTH];
   logic [FIFO_DEPTH_W-1:0] wr_ptr  [NP];
   logic [FIFO_DEPTH_W-1:0] rd_ptr  [NP];
   logic [FIFO_DEPTH_W:0]   count   [NP];
   logic [PW-1:0]           head    [NP];
   logic [2:0]              route   [NP];
   logic [NP-1:0]           req     [NP];   // req[o][i]: input i wants output o
   logic [2:0]              gnt_idx [NP];
   logic [2:0]              ptr     [NP];   // last granted input per output
   logic [2:0]              cand;
   logic [NP-1:0]           nonempty, head_ok, push, pop, drop_wr, drop_rt, out_vld;
   logic [3:0]              drop_inc;
   logic [8:0]              drop_sum;

   // Per-input FIFO status and head routing.
   // NOTE: every always_comb output gets a value on every path (here directly,
   // elsewhere via a default first) so no latch is inferred.
   always_comb begin
      for (int p = 0; p < NP; p++) begin
         head[p]     = mem[p][rd_ptr[p]];
         nonempty[p] = (count[p] != '0);
         head_ok[p]  = (int'(head[p][CA-1:0]) < COL_M) && (int'(head[p][CA+RA-1:CA]) < ROW_N);
         route[p]    = calc_route(int'(head[p][CA-1:0]), int'(head[p][CA+RA-1:CA]));
         // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
         push[p]     = wr_en_i[p] && (count[p] != CNT_DEPTH);
         drop_wr[p]  = wr_en_i[p] && (count[p] == CNT_DEPTH);
         drop_rt[p]  = nonempty[p] && !head_ok[p];
         // One slot stays reserved for the packet already on the registered link.
         full_o[p]   = (count[p] >= CNT_ALMOST);
      end
   end

   // Output arbitration. Loops run from the back so the final overwrite is the
   // first candidate in search order.
   always_comb begin
      cand = '0;
      for (int o = 0; o < NP; o++) begin
         gnt_idx[o] = '0;
         for (int i = 0; i < NP; i++)
            req[o][i] = nonempty[i] && head_ok[i] && (route[i] == 3'(o)) && !nxt_full_i[o];
         if (ARB_TYPE == 0) begin
            for (int i = NP - 1; i >= 0; i--)
               if (req[o][i]) gnt_idx[o] = 3'(i);
         end else begin
            for (int k = NP; k >= 1; k--) begin
               cand = 3'((int'(ptr[o]) + k) % NP);
               if (req[o][cand]) gnt_idx[o] = cand;
            end
         end
         out_vld[o] = |req[o];
      end
   end

   // Pops: granted heads plus heads with an unreachable address.
   always_comb begin
      pop = drop_rt;
      for (int o = 0; o < NP; o++)
         if (out_vld[o]) pop[gnt_idx[o]] = 1'b1;
      drop_inc = '0;
      for (int p = 0; p < NP; p++)
         drop_inc = drop_inc + 4'(drop_wr[p]) + 4'(drop_rt[p]);
      drop_sum = {1'b0, drop_cnt_o} + {5'b0, drop_inc};
   end

   // NOTE: the payload array is not reset; pointers and counts alone decide
   // which entries are live, so stale contents are never forwarded.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NP; p++)
         if (push[p]) mem[p][wr_ptr[p]] <= pckt_i[PW*p +: PW];
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < NP; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            count[p]  <= '0;
            ptr[p]    <= 3'd4;   // first search after reset starts at index 0
         end
         ovrflw_o   <= '0;
         wr_en_o    <= '0;
         pckt_o     <= '0;
         drop_cnt_o <= '0;
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
            if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
            case ({push[p], pop[p]})
               2'b10:   count[p] <= count[p] + 1'b1;
               2'b01:   count[p] <= count[p] - 1'b1;
               default: count[p] <= count[p];
            endcase
         end
         for (int o = 0; o < NP; o++) begin
            wr_en_o[o] <= out_vld[o];
            if (out_vld[o]) begin
               pckt_o[PW*o +: PW] <= head[gnt_idx[o]];
               ptr[o]             <= gnt_idx[o];
            end
         end
         ovrflw_o   <= ovrflw_o | drop_wr;
         drop_cnt_o <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_xy_router_rr.sv
// -----------------------------------------------------------------------------
// tb_xy_router_rr
// Scoreboard bench for xy_router_rr. Two instances: a 3x3 mesh router at (1,1)
// with round-robin arbitration, and a 3x3 torus router at (0,0) with fixed
// priority. Directed stimulus pushes expected packets into per-output queues;
// a negedge monitor pops and compares whenever wr_en_o is asserted.
// -----------------------------------------------------------------------------
module tb_xy_router_rr;

   localparam int PW = 12;   // 8 data + 2 row + 2 col

   logic          clk = 1'b0;
   logic          rst_i;

   logic [4:0]    wr_en_i, nxt_full_i, full_o, ovrflw_o, wr_en_o;
   logic [5*PW-1:0] pckt_i, pckt_o;
   logic [7:0]    drop_cnt_o;

   logic [4:0]    t_wr_en_i, t_nxt_full_i, t_full_o, t_ovrflw_o, t_wr_en_o;
   logic [5*PW-1:0] t_pckt_i, t_pckt_o;
   logic [7:0]    t_drop_cnt_o;

   logic [PW-1:0] exp_q   [5][$];
   logic [PW-1:0] t_exp_q [5][$];
   logic [PW-1:0] exp_v;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   xy_router_rr #(
      .ROW_N(3), .COL_M(3), .ROW_CORD(1), .COL_CORD(1), .PCKT_DATA_W(8),
      .FIFO_DEPTH_W(2), .TORUS(0), .ARB_TYPE(1)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .pckt_i(pckt_i),
      .full_o(full_o), .ovrflw_o(ovrflw_o), .nxt_full_i(nxt_full_i),
      .wr_en_o(wr_en_o), .pckt_o(pckt_o), .drop_cnt_o(drop_cnt_o)
   );

   xy_router_rr #(
      .ROW_N(3), .COL_M(3), .ROW_CORD(0), .COL_CORD(0), .PCKT_DATA_W(8),
      .FIFO_DEPTH_W(2), .TORUS(1), .ARB_TYPE(0)
   ) dut_t (
      .clk_i(clk), .rst_i(rst_i), .wr_en_i(t_wr_en_i), .pckt_i(t_pckt_i),
      .full_o(t_full_o), .ovrflw_o(t_ovrflw_o), .nxt_full_i(t_nxt_full_i),
      .wr_en_o(t_wr_en_o), .pckt_o(t_pckt_o), .drop_cnt_o(t_drop_cnt_o)
   );

   function automatic logic [PW-1:0] mk(input logic [7:0] d, input logic [1:0] r, input logic [1:0] c);
      return {d, r, c};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One cycle: past the next rising edge, away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst_i) begin
         for (int o = 0; o < 5; o++) begin
            if (wr_en_o[o]) begin
               if (exp_q[o].size() == 0) check($sformatf("mesh_unexpected_out%0d", o), 1, 0);
               else begin
                  exp_v = exp_q[o].pop_front();
                  check($sformatf("mesh_pckt_out%0d", o), pckt_o[PW*o +: PW], exp_v);
               end
            end
            if (t_wr_en_o[o]) begin
               if (t_exp_q[o].size() == 0) check($sformatf("torus_unexpected_out%0d", o), 1, 0);
               else begin
                  exp_v = t_exp_q[o].pop_front();
                  check($sformatf("torus_pckt_out%0d", o), t_pckt_o[PW*o +: PW], exp_v);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  sent [4];
      logic saw1, saw3;

      rst_i = 1'b1;
      wr_en_i = '0; pckt_i = '0; nxt_full_i = '0;
      t_wr_en_i = '0; t_pckt_i = '0; t_nxt_full_i = '0;
      repeat (3) step();
      rst_i = 1'b0;

      // Reset state
      check("rst_wr_en",  wr_en_o,    0);
      check("rst_full",   full_o,     0);
      check("rst_ovrflw", ovrflw_o,   0);
      check("rst_drop",   drop_cnt_o, 0);
      check("rst_pckt",   pckt_o,     0);

      // Single packet local -> down, 2-cycle latency
      wr_en_i[0] = 1'b1;
      pckt_i[0 +: PW] = mk(8'hA5, 2'd2, 2'd1);
      exp_q[4].push_back(mk(8'hA5, 2'd2, 2'd1));
      step();
      wr_en_i = '0;
      check("lat_edge_k", wr_en_o, 5'b00000);
      step();
      check("lat_edge_k1", wr_en_o, 5'b10000);
      check("lat_pckt4", pckt_o[4*PW +: PW], mk(8'hA5, 2'd2, 2'd1));
      step();
      check("lat_after", wr_en_o, 5'b00000);

      // Round-robin: ports 1,2,3 stream to local; grants rotate 1,2,3
      for (int n = 0; n < 6; n++)
         for (int p = 1; p <= 3; p++)
            exp_q[0].push_back(mk(8'(p * 16 + n), 2'd1, 2'd1));
      for (int p = 0; p < 4; p++) sent[p] = 0;
      saw1 = 1'b0; saw3 = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         wr_en_i = '0;
         for (int p = 1; p <= 3; p++) begin
            if (sent[p] < 6 && !full_o[p]) begin
               wr_en_i[p] = 1'b1;
               pckt_i[PW*p +: PW] = mk(8'(p * 16 + sent[p]), 2'd1, 2'd1);
               sent[p]++;
            end
         end
         step();
         if (cyc < 4) begin
            saw1 = saw1 | full_o[1];
            saw3 = saw3 | full_o[3];
         end
      end
      wr_en_i = '0;
      check("rr_full1_within4", saw1, 1);
      check("rr_full3_within4", saw3, 1);
      check("rr_no_ovrflw", ovrflw_o, 0);
      check("rr_drained", exp_q[0].size(), 0);

      // Downstream blocked: fill, overflow, then drain back-to-back
      nxt_full_i[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_en_i[0] = 1'b1;
         pckt_i[0 +: PW] = mk(8'(8'h30 + k), 2'd1, 2'd2);
         exp_q[3].push_back(mk(8'(8'h30 + k), 2'd1, 2'd2));
         step();
         if (k == 1) check("blk_not_full_2", full_o[0], 0);
         if (k == 2) check("blk_full_3", full_o[0], 1);
      end
      pckt_i[0 +: PW] = mk(8'hEE, 2'd1, 2'd2);
      step();
      wr_en_i = '0;
      check("ovf_flag", ovrflw_o, 5'b00001);
      check("ovf_drop_cnt", drop_cnt_o, 1);
      check("blk_no_output", wr_en_o, 0);
      nxt_full_i = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("drain_cycle%0d", k), wr_en_o, 5'b01000);
      end
      step();
      check("drain_done", wr_en_o, 0);
      check("drain_full_clr", full_o, 0);

      // Reset with packets queued
      nxt_full_i[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wr_en_i[0] = 1'b1;
         pckt_i[0 +: PW] = mk(8'(8'h40 + k), 2'd1, 2'd2);
         step();
      end
      check("prerst_full", full_o[0], 1);
      rst_i = 1'b1;
      pckt_i[0 +: PW] = mk(8'h4F, 2'd1, 2'd2);
      step();
      rst_i = 1'b0;
      wr_en_i = '0;
      nxt_full_i = '0;
      check("rst2_full",   full_o,     0);
      check("rst2_ovrflw", ovrflw_o,   0);
      check("rst2_drop",   drop_cnt_o, 0);
      check("rst2_wr_en",  wr_en_o,    0);
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("rst2_quiet%0d", k), wr_en_o, 0);
      end

      // Invalid addresses: column out of range, then rows, saturating counter
      wr_en_i[0] = 1'b1;
      pckt_i[0 +: PW] = mk(8'h77, 2'd1, 2'd3);
      step();
      wr_en_i = '0;
      step();
      check("inv_drop1", drop_cnt_o, 1);
      check("inv_no_out", wr_en_o, 0);
      for (int i = 0; i < 253; i++) begin
         wr_en_i[0] = 1'b1;
         pckt_i[0 +: PW] = mk(8'(i), 2'd3, 2'd1);
         step();
      end
      wr_en_i = '0;
      repeat (2) step();
      check("inv_drop254", drop_cnt_o, 254);
      for (int i = 0; i < 47; i++) begin
         wr_en_i[0] = 1'b1;
         pckt_i[0 +: PW] = mk(8'(i), 2'd3, 2'd1);
         step();
      end
      wr_en_i = '0;
      repeat (2) step();
      check("inv_drop_sat", drop_cnt_o, 255);
      check("inv_no_ovrflw", ovrflw_o, 0);

      // Torus router (0,0): wrap-aware direction choice
      t_wr_en_i[0] = 1'b1;
      t_pckt_i[0 +: PW] = mk(8'h11, 2'd0, 2'd2); t_exp_q[1].push_back(mk(8'h11, 2'd0, 2'd2)); step();
      t_pckt_i[0 +: PW] = mk(8'h12, 2'd0, 2'd1); t_exp_q[3].push_back(mk(8'h12, 2'd0, 2'd1)); step();
      t_pckt_i[0 +: PW] = mk(8'h13, 2'd2, 2'd0); t_exp_q[2].push_back(mk(8'h13, 2'd2, 2'd0)); step();
      t_pckt_i[0 +: PW] = mk(8'h14, 2'd1, 2'd0); t_exp_q[4].push_back(mk(8'h14, 2'd1, 2'd0)); step();
      t_wr_en_i = '0;
      repeat (4) step();

      // Fixed priority: after port 1 wins alone, a 1-vs-3 contest still goes to 1
      t_wr_en_i[1] = 1'b1;
      t_pckt_i[PW*1 +: PW] = mk(8'h21, 2'd0, 2'd0);
      t_exp_q[0].push_back(mk(8'h21, 2'd0, 2'd0));
      step();
      t_wr_en_i = '0;
      repeat (4) step();
      t_wr_en_i[1] = 1'b1;
      t_wr_en_i[3] = 1'b1;
      t_pckt_i[PW*1 +: PW] = mk(8'h31, 2'd0, 2'd0);
      t_pckt_i[PW*3 +: PW] = mk(8'h33, 2'd0, 2'd0);
      t_exp_q[0].push_back(mk(8'h31, 2'd0, 2'd0));
      t_exp_q[0].push_back(mk(8'h33, 2'd0, 2'd0));
      step();
      t_wr_en_i = '0;
      repeat (5) step();
      check("torus_drop", t_drop_cnt_o, 0);

      for (int o = 0; o < 5; o++) begin
         check($sformatf("mesh_queue_empty%0d", o), exp_q[o].size(), 0);
         check($sformatf("torus_queue_empty%0d", o), t_exp_q[o].size(), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
